// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-store controller:
// FSM states, store geometry and the byte-lane placement within a word.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH     = 64;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } imem_state_e;

  // Lane 0 is the first byte of the instruction and lands in the top byte.
  localparam logic [3:0][4:0] LANE_LSB = {5'd0, 5'd8, 5'd16, 5'd24};

  function automatic logic [31:0] lane_place(input logic [1:0] lane, input logic [7:0] b);
    return {24'd0, b} << LANE_LSB[lane];
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs the byte-serial load stream into 32-bit words. word_wr_o fires in the
// cycle the final byte of a word is presented; short words come out zero-filled.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic        word_wr_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] partial_q, partial_d;

  // Lanes above the current one are still zero in partial_q, which gives zero-fill for free.
  always_comb begin
    word_o    = partial_q | lane_place(lane_q, byte_i);
    word_wr_o = byte_valid_i & (last_i | (lane_q == LAST_LANE));
    lane_d    = lane_q;
    partial_d = partial_q;
    if (clr_i) begin
      lane_d    = 2'd0;
      partial_d = 32'd0;
    end else if (word_wr_o) begin
      lane_d    = 2'd0;
      partial_d = 32'd0;
    end else if (byte_valid_i) begin
      lane_d    = lane_q + 2'd1;
      partial_d = word_o;
    end else begin
      lane_d    = lane_q;
      partial_d = partial_q;
    end
  end

  // Lane counter and partially assembled word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q    <= 2'd0;
      partial_q <= 32'd0;
    end else begin
      lane_q    <= lane_d;
      partial_q <= partial_d;
    end
  end

endmodule

// File: rtl/imem_load_fetch_ctrl.sv
// Instruction store owner: clears the array after reset, serves registered fetches,
// and accepts byte-serial program loads. Optional address checking: IMEM_ADDR_CHECK_EN.
module imem_load_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  imem_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [IDX_W-1:0] word_ptr_q, word_ptr_d;
  logic [31:0]      mem_q [DEPTH];

  logic             fetch_valid_q, fetch_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic [31:0]      fetch_instr_q, fetch_instr_d;
  logic             load_done_q, load_done_d;

  logic             fetch_acc_s;
  logic             fetch_bad_s;
  logic [IDX_W-1:0] fetch_idx_s;
  logic             asm_clr_s;
  logic             asm_valid_s;
  logic             word_wr_s;
  logic [31:0]      word_s;

  assign fetch_acc_s = (state_q == RUN) && fetch_req;
  assign fetch_idx_s = fetch_addr[IDX_W+1:2];
  assign asm_clr_s   = (state_q == RUN) && load_start;
  assign asm_valid_s = (state_q == LOAD) && load_valid;

`ifdef IMEM_ADDR_CHECK_EN
  // DEPTH is a power of two, so "index >= DEPTH" is any set bit above the index field.
  assign fetch_bad_s = (fetch_addr[1:0] != 2'd0) || (fetch_addr[ADDR_W-1:IDX_W+2] != '0);
`else
  logic unused_addr_s;
  assign unused_addr_s = ^{fetch_addr[ADDR_W-1:IDX_W+2], fetch_addr[1:0]};
  assign fetch_bad_s   = 1'b0;
`endif

  imem_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (asm_clr_s),
    .byte_valid_i (asm_valid_s),
    .byte_i       (load_byte),
    .last_i       (load_last),
    .word_wr_o    (word_wr_s),
    .word_o       (word_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: loads end on the last byte or once the final word is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: begin
        if (clr_ptr_q == LAST_IDX) state_d = RUN;
        else                       state_d = CLEAR;
      end
      RUN: begin
        if (load_start) state_d = LOAD;
        else            state_d = RUN;
      end
      LOAD: begin
        if (word_wr_s && (load_last || (word_ptr_q == LAST_IDX))) state_d = RUN;
        else                                                    state_d = LOAD;
      end
      default: state_d = CLEAR;
    endcase
  end

  // FSM outputs and pointer updates, all registered below.
  always_comb begin
    fetch_valid_d = fetch_acc_s;
    fetch_instr_d = fetch_instr_q;
    fetch_err_d   = fetch_err_q;
    if (fetch_acc_s) begin
      if (fetch_bad_s) begin
        fetch_instr_d = 32'd0;
        fetch_err_d   = 1'b1;
      end else begin
        fetch_instr_d = mem_q[fetch_idx_s];
        fetch_err_d   = 1'b0;
      end
    end else begin
      fetch_instr_d = fetch_instr_q;
      fetch_err_d   = fetch_err_q;
    end

    load_done_d = (state_q == LOAD) && (state_d == RUN);

    if (state_q == CLEAR) clr_ptr_d = clr_ptr_q + IDX_W'(1);
    else                  clr_ptr_d = '0;

    word_ptr_d = word_ptr_q;
    if (asm_clr_s) begin
      word_ptr_d = '0;
    end else if ((state_q == LOAD) && word_wr_s && (word_ptr_q != LAST_IDX)) begin
      word_ptr_d = word_ptr_q + IDX_W'(1);
    end else begin
      word_ptr_d = word_ptr_q;
    end
  end

  // Registered outputs and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'd0;
      fetch_err_q   <= 1'b0;
      load_done_q   <= 1'b0;
      clr_ptr_q     <= '0;
      word_ptr_q    <= '0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_err_q   <= fetch_err_d;
      load_done_q   <= load_done_d;
      clr_ptr_q     <= clr_ptr_d;
      word_ptr_q    <= word_ptr_d;
    end
  end

  // Storage array; contents are established by the CLEAR sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_ptr_q] <= 32'd0;
    end else if ((state_q == LOAD) && word_wr_s) begin
      mem_q[word_ptr_q] <= word_s;
    end
  end

  assign fetch_ready = (state_q == RUN);
  assign load_ready  = (state_q == LOAD);
  assign busy        = (state_q != RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_err   = fetch_err_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Randomized bench for imem_load_fetch_ctrl against a word-array reference model.
module tb_imem_load_fetch_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        fetch_ready, fetch_valid, fetch_err;
  logic [31:0] fetch_instr;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic        load_last = 1'b0;
  logic        load_ready, load_done, busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  load_q [$];

  always #5 clk = ~clk;

  imem_load_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {err, instr} for a fetch of byte address a.
  function automatic logic [32:0] ref_fetch(input logic [31:0] a);
    int idx;
`ifdef IMEM_ADDR_CHECK_EN
    if ((a % 4) != 0 || (a / 4) >= DEPTH) return {1'b1, 32'd0};
    idx = int'(a / 4);
`else
    idx = int'((a / 4) % DEPTH);
`endif
    return {1'b0, ref_mem[idx]};
  endfunction

  task automatic check_reset_vals(input string where);
    check({where, "_fetch_ready"}, fetch_ready, 32'd0);
    check({where, "_fetch_valid"}, fetch_valid, 32'd0);
    check({where, "_fetch_instr"}, fetch_instr, 32'd0);
    check({where, "_fetch_err"},   fetch_err,   32'd0);
    check({where, "_load_ready"},  load_ready,  32'd0);
    check({where, "_load_done"},   load_done,   32'd0);
    check({where, "_busy"},        busy,        32'd1);
  endtask

  // Release reset and count cycles until the store is usable.
  task automatic release_and_clear();
    int cnt = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    reset = 1'b0;
    check("clear_busy", busy, 32'd1);
    while (!fetch_ready && cnt < 200) begin
      step();
      cnt++;
    end
    check("clear_cycles", cnt, DEPTH);
    check("run_busy", busy, 32'd0);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    logic [32:0] exp;
    exp = ref_fetch(a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    check("fetch_valid", fetch_valid, 32'd1);
    check("fetch_err",   fetch_err,   {31'd0, exp[32]});
    check("fetch_instr", fetch_instr, exp[31:0]);
    if ($urandom_range(0, 1) == 0) begin
      step();
      check("fetch_idle_valid", fetch_valid, 32'd0);
      check("fetch_hold_instr", fetch_instr, exp[31:0]);
    end
  endtask

  // Load the bytes in load_q; the model places byte n in word n/4, lane n%4.
  task automatic do_load(input bit use_last, input bit with_fetch, input logic [31:0] fa);
    logic [32:0] exp;
    logic [31:0] tmp;
    int          n, lane;
    bit          last;
    n   = load_q.size();
    exp = ref_fetch(fa);
    load_start = 1'b1;
    fetch_req  = with_fetch;
    fetch_addr = fa;
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("load_ready", load_ready, 32'd1);
    check("load_busy",  busy,       32'd1);
    check("load_fetch_ready", fetch_ready, 32'd0);
    if (with_fetch) begin
      check("simul_fetch_valid", fetch_valid, 32'd1);
      check("simul_fetch_instr", fetch_instr, exp[31:0]);
    end
    tmp = 32'd0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        fetch_req  = $urandom_range(0, 1) == 1;
        fetch_addr = $urandom_range(0, 255);
        step();
        fetch_req = 1'b0;
        check("fetch_blocked", fetch_valid, 32'd0);
      end
      lane = i % 4;
      if (lane == 0) tmp = 32'd0;
      tmp[31 - 8*lane -: 8] = load_q[i];
      last = use_last && (i == n - 1);
      load_valid = 1'b1;
      load_byte  = load_q[i];
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (lane == 3 || last) ref_mem[i / 4] = tmp;
      if (i == n - 1) begin
        check("load_done",         load_done,   32'd1);
        check("done_fetch_ready",  fetch_ready, 32'd1);
        check("done_load_ready",   load_ready,  32'd0);
      end else begin
        check("load_done_early", load_done, 32'd0);
      end
    end
    step();
    check("load_done_pulse", load_done, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          len;

    #2;
    check_reset_vals("reset");
    step();
    release_and_clear();
    do_fetch(32'h0);

    load_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    do_load(1'b1, 1'b0, 32'h0);
    do_fetch(32'h0);
    check("ref_word0", ref_mem[0], 32'h8C010004);
    do_fetch(32'h4);
    check("ref_word1", ref_mem[1], 32'h00221820);

    load_q = '{8'hAA, 8'hBB};
    do_load(1'b1, 1'b0, 32'h0);
    do_fetch(32'h0);
    do_fetch(32'h4);

    load_q = '{8'h11, 8'h22, 8'h33};
    do_load(1'b1, 1'b1, 32'h4);

    do_fetch(32'h102);
    do_fetch(32'h100);
    do_fetch(32'h0);

    // Full-length load with no last marker exits on its own.
    load_q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) load_q.push_back(8'($urandom));
    do_load(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) do_fetch(32'($urandom_range(0, DEPTH - 1)) * 4);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        load_q.delete();
        len = $urandom_range(1, 24);
        for (int i = 0; i < len; i++) load_q.push_back(8'($urandom));
        a = 32'($urandom_range(0, 255));
        do_load(1'b1, $urandom_range(0, 1) == 1, a);
      end else begin
        if ($urandom_range(0, 4) == 0) a = $urandom;
        else                           a = 32'($urandom_range(0, 300));
        do_fetch(a);
      end
    end

    // Reset during a load discards the partial word and restarts CLEAR.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'($urandom);
      step();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midload_reset");
    step();
    release_and_clear();
    do_fetch(32'h0);
    for (int i = 0; i < 6; i++) do_fetch(32'($urandom_range(0, 255)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_load_fetch_ctrl.md
# imem_load_fetch_ctrl

Controller and owner of the CPU instruction store. It holds a 64-word, byte-organised instruction array and shares it between two requesters: the CPU fetch port (read) and a byte-serial program loader (write). After reset it clears the array, then serves fetches. On request it switches to a load phase that packs bytes into words and writes them. It sits between the PC/fetch stage and the debug/boot loader path.

## Interface
- DEPTH, 64, number of 32-bit instruction words (power of two)
- ADDR_W, 32, fetch byte-address width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request, sampled when fetch_ready=1
- fetch_addr  in  ADDR_W  byte address of the instruction
- fetch_ready  out  1  high only in RUN
- fetch_valid  out  1  one-cycle pulse, response present
- fetch_instr  out  32  fetched word, byte 0 of word in bits [31:24]
- fetch_err  out  1  qualifies fetch_valid; address rejected
- load_start  in  1  request entry to LOAD (honoured only in RUN)
- load_valid  in  1  load byte present
- load_byte  in  8  load data
- load_last  in  1  marks final byte, qualified by load_valid
- load_ready  out  1  high only in LOAD
- load_done  out  1  one-cycle pulse on LOAD→RUN
- busy  out  1  high in CLEAR or LOAD

## Operation
- States: CLEAR, RUN, LOAD.
  - Reset enters CLEAR with clear pointer 0.
  - CLEAR writes word ptr=0, increments ptr every cycle, and goes to RUN after writing word DEPTH-1 (DEPTH cycles).
- RUN: a fetch is accepted when fetch_req=1. The word index is fetch_addr[31:2]. The response is registered.
  - Normal: fetch_instr = {mem[i][0], mem[i][1], mem[i][2], mem[i][3]}, fetch_err=0.
  - When rejected (see Configuration): fetch_instr=0, fetch_err=1.
  - Without a request, fetch_valid=0 and fetch_instr holds its last value.
- RUN + load_start=1 → LOAD. Word pointer and byte lane are reset to 0.
- LOAD: each load_valid byte is placed in lane = byte counter (lane 0 first, mapped to bits [31:24]).
  - The 4th byte writes the assembled word to mem[word_ptr], then word_ptr++ and lane resets to 0.
  - load_last on lane k<3: remaining lanes are zero-filled and the word is written in that same cycle.
  - LOAD exits to RUN on load_last, or automatically after byte 4*DEPTH. No wrap-around; the pointer never exceeds DEPTH-1.
  - Words not reached in this load keep their prior contents.
- Simultaneous fetch_req and load_start in RUN: the fetch is accepted and returns pre-load contents next cycle; the state still goes to LOAD.
- fetch_req in CLEAR/LOAD is ignored because fetch_ready=0. The requester holds its request.
- Reset mid-LOAD or mid-CLEAR aborts the operation and restarts CLEAR. A partial word is discarded.

## Timing
- Reset values: fetch_ready=0, fetch_valid=0, fetch_instr=0, fetch_err=0, load_ready=0, load_done=0, busy=1, state=CLEAR.
- Fetch latency: 1 cycle (accepted at edge N, fetch_valid high during cycle N+1). Throughput is 1 fetch per cycle.
- Load: 1 byte per cycle. The word write happens on the edge that accepts its final byte.
- load_done is high the cycle after the edge that accepts the final byte, with state=RUN. fetch_ready is high in that same cycle.
- CLEAR lasts exactly DEPTH cycles after reset deassertion.

## Configuration
- IMEM_ADDR_CHECK_EN defined: a fetch is rejected when fetch_addr[1:0]≠0 or fetch_addr[ADDR_W-1:2] ≥ DEPTH.
- IMEM_ADDR_CHECK_EN undefined: no rejection. Index = fetch_addr[log2(DEPTH)+1:2] (aliasing wrap), low bits ignored, fetch_err tied to 0.

## Structure
- Package imem_pkg holds:
  - state enum {CLEAR, RUN, LOAD}
  - IMEM_DEPTH=64, BYTES_PER_WORD=4
  - lane-to-bit-slice mapping constant (lane 0 → [31:24])
- Sub-module imem_word_assembler: lane counter, byte packing, zero-fill on last, word_wr strobe.
- The top level holds the FSM, array, pointers, fetch path and address check.

## Test plan
- Reset deasserted → busy=1 for 64 cycles, then fetch_ready=1. A fetch of 0x00 returns 0x00000000, fetch_err=0.
- Load bytes 0x8C,0x01,0x00,0x04 then 0x00,0x22,0x18,0x20 (last) → load_done pulse. Fetch 0x0 → 0x8C010004; fetch 0x4 → 0x00221820.
- Load 0xAA,0xBB with load_last on 0xBB → mem[0]=0xAABB0000. Fetch 0x0 returns it; word 1 is unchanged.
- Same-cycle fetch_req(addr 0x4) and load_start → next cycle fetch_valid with old word 1, load_ready=1.
- With IMEM_ADDR_CHECK_EN: fetch 0x102 → fetch_err=1, instr 0; fetch 0x100 → fetch_err=1. Without it: 0x100 returns word 0.
- Reset asserted after 2 load bytes → outputs at reset values immediately. After CLEAR, word 0 = 0.
